rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
Shares the register file's two write ports among four writeback requesters: pipe0 ALU (req0), pipe1 ALU (req1), load unit (req2) and mul/div unit (req3). Each cycle it grants at most two requests and drives the packed register-file write bus from registers, one cycle after the grant. Req0 has fixed top priority. Req2/req3 share the remaining slots round-robin, with starvation promotion over req1. Sits between the EX/MEM writeback sources and Reg_File.

Parameters:
ADDR_W, 5, register address width
DATA_W, 32, register data width
STARVE_LIMIT, 4, wait cycles after which req2/req3 is promoted above req1 (1..15)

Ports:
wba_in_clk  in  1  clock
wba_in_rstL  in  1  reset, asynchronous, active-low
req_valid  in  4  per-requester write request, bit i = req i
req_waddr  in  4*ADDR_W  destination register, slice i = req i
req_wdata  in  4*DATA_W  write data, slice i = req i
req_ready  out  4  grant, combinational; a transfer occurs when valid&ready
flush  in  1  pipeline flush; kills req1..req3 grants this cycle
write_obus  out  2*(1+ADDR_W+DATA_W)  {we2,waddr2,wdata2,we1,waddr1,wdata1}, matches register-file write bus
stall_cnt  out  16  saturating count of cycles with at least one valid request not granted

Behaviour:
- Reset (async, wba_in_rstL=0): write_obus=0, stall_cnt=0, starvation counters=0, rr_ptr=req2. req_ready is 0 while in reset.
- Requester rule: once asserted, valid/waddr/wdata hold until ready. req_ready depends only on the current req_valid, req_waddr, flush and internal state.
- Starvation counters starv2 and starv3 (4-bit, saturating):
  - +1 each cycle the requester is valid and not granted.
  - Clear to 0 on grant, or when the requester is not valid.
  - A requester is starving when its counter >= STARVE_LIMIT.
- Candidate order each cycle:
  1. req0
  2. starving req2/req3, rr order
  3. req1
  4. non-starving req2/req3, rr order
  - rr order: rr_ptr first, then the other.
- Selection:
  - Walk the candidate order over valid requests; take the first two.
  - Skip a candidate whose waddr is nonzero and equal to the waddr already selected. That candidate waits, with no same-cycle merge.
  - First selected goes to port1, second to port2.
- Grant: req_ready[i]=1 for selected requesters.
- Flush: when flush=1, only req0 may be granted. Other requests stay pending (not dropped) and their starvation counters hold.
- rr_ptr: toggles to the other requester in any cycle where the requester it points at is granted. Otherwise unchanged.
- Output register (next edge after grant):
  - weK = 1 if port K was selected and waddrK != 0.
  - waddrK/wdataK load from the selected requester; they are zero when port K is unselected.
  - waddr=0 requests are granted normally but produce weK=0.
- Latency: grant in cycle N, register-file write visible on write_obus in N+1, written at the end of N+1.
- Guarantee: we1&we2 never both asserted with waddr1==waddr2.
- stall_cnt: increments when any valid bit is ungranted in a cycle; saturates at 0xFFFF.
- Reset mid-operation: all state clears immediately. Any in-flight write_obus content is discarded.

Decomposition:
- Shared include/package: ADDR_W/DATA_W defaults; the write-bus width macro and field packing order shared with the register-file bus definitions; requester index constants REQ_ALU0=0, REQ_ALU1=1, REQ_LSU=2, REQ_MDU=3.
- One natural sub-module: rf_wb_pick2. Combinational; from the ordered candidate vector and addresses it returns two one-hot selects with the same-address skip. Counters, rr_ptr and output flops stay in the top module.

Test Plan:
- All four valid, addrs 1,2,3,4, counters 0 → ready=0011. Next cycle write_obus: port1 r1, port2 r2, we1=we2=1.
- req2 and req3 valid alone, addrs 5,6, rr_ptr=req2 → both granted (2 on port1, 3 on port2); rr_ptr toggles to req3.
- req0 and req1 held valid every cycle with new addrs, req2 valid addr 7, STARVE_LIMIT=4 → req2 ungranted 4 cycles, then granted in cycle 5 over req1; starv2 returns to 0.
- req0 addr 9 and req1 addr 9 valid, req2 addr 10 → grants req0 and req2; req1 waits and is granted next cycle.
- req0 addr 0 and req1 addr 3 → both granted; we1=0, we2=1, waddr2=3.
- flush=1 with req0..req3 valid → ready=0001. Assert rstL=0 mid-stream → write_obus=0 and stall_cnt=0 asynchronously.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: requester ids,
// default widths, write-bus sizing and the starvation counter update rule.
package rf_wb_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned DATA_W_DEF = 32;

    typedef logic [1:0] req_idx_t;

    localparam req_idx_t REQ_ALU0 = 2'd0;
    localparam req_idx_t REQ_ALU1 = 2'd1;
    localparam req_idx_t REQ_LSU  = 2'd2;
    localparam req_idx_t REQ_MDU  = 2'd3;

    // Bus packing, MSB first: {we2, waddr2, wdata2, we1, waddr1, wdata1}.
    function automatic int unsigned wb_bus_w(input int unsigned aw, input int unsigned dw);
        return 2 * (1 + aw + dw);
    endfunction

    function automatic logic [3:0] starv_next(input logic       valid,
                                              input logic       granted,
                                              input logic       hold,
                                              input logic [3:0] cur);
        if (hold) return cur;
        if (!valid || granted) return 4'd0;
        return (cur == 4'hF) ? cur : cur + 4'd1;
    endfunction

endpackage

// File: rtl/rf_wb_pick2.sv
// Picks the first two valid entries of an ordered candidate list, skipping a
// second candidate that targets the same nonzero register as the first.
module rf_wb_pick2
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic [3:0]          cand_valid,
    input  logic [4*ADDR_W-1:0] cand_addr,
    output logic [3:0]          sel1,
    output logic [3:0]          sel2
);

    logic              found1;
    logic              found2;
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W-1:0] addr;

    always_comb begin
        sel1       = '0;
        sel2       = '0;
        found1     = 1'b0;
        found2     = 1'b0;
        first_addr = '0;
        addr       = '0;
        for (int k = 0; k < 4; k++) begin
            addr = cand_addr[k*ADDR_W +: ADDR_W];
            if (cand_valid[k]) begin
                if (!found1) begin
                    sel1[k]    = 1'b1;
                    found1     = 1'b1;
                    first_addr = addr;
                end else if (!found2 && !((addr != '0) && (addr == first_addr))) begin
                    sel2[k] = 1'b1;
                    found2  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-port register-file writeback arbiter for four requesters: fixed-priority
// ALU0, round-robin LSU/MDU with starvation promotion over ALU1, registered bus.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                                 wba_in_clk,
    input  logic                                 wba_in_rstL,
    input  logic [3:0]                           req_valid,
    input  logic [4*ADDR_W-1:0]                  req_waddr,
    input  logic [4*DATA_W-1:0]                  req_wdata,
    output logic [3:0]                           req_ready,
    input  logic                                 flush,
    output logic [wb_bus_w(ADDR_W, DATA_W)-1:0]  write_obus,
    output logic [15:0]                          stall_cnt
);

    localparam logic [3:0]  STARVE_LIM = 4'(STARVE_LIMIT);
    localparam int unsigned BUS_W      = wb_bus_w(ADDR_W, DATA_W);

    logic             rr_q, rr_d;  // 0: LSU goes first, 1: MDU goes first
    logic [3:0]       starv2_q, starv2_d, starv3_q, starv3_d;
    logic [15:0]      stall_q, stall_d;
    logic [BUS_W-1:0] bus_q, bus_d;

    req_idx_t         rr_first, rr_second;
    logic             first_starving, second_starving;
    req_idx_t [3:0]   ord;
    logic [3:0]       elig, cand_valid, sel1, sel2, grant1, grant2, grant;
    logic [4*ADDR_W-1:0] cand_addr;
    logic [ADDR_W-1:0]   addr1, addr2;
    logic [DATA_W-1:0]   data1, data2;

    assign rr_first        = rr_q ? REQ_MDU : REQ_LSU;
    assign rr_second       = rr_q ? REQ_LSU : REQ_MDU;
    assign first_starving  = req_valid[rr_first] &&
                             ((rr_q ? starv3_q : starv2_q) >= STARVE_LIM);
    assign second_starving = req_valid[rr_second] &&
                             ((rr_q ? starv2_q : starv3_q) >= STARVE_LIM);

    // Only ALU0 is allowed through during a flush.
    assign elig = flush ? {3'b000, req_valid[REQ_ALU0]} : req_valid;

    always_comb begin
        ord[0] = REQ_ALU0;
        unique case ({first_starving, second_starving})
            2'b11: begin ord[1] = rr_first;  ord[2] = rr_second; ord[3] = REQ_ALU1;  end
            2'b10: begin ord[1] = rr_first;  ord[2] = REQ_ALU1;  ord[3] = rr_second; end
            2'b01: begin ord[1] = rr_second; ord[2] = REQ_ALU1;  ord[3] = rr_first;  end
            default: begin ord[1] = REQ_ALU1; ord[2] = rr_first; ord[3] = rr_second; end
        endcase
        cand_valid = '0;
        cand_addr  = '0;
        for (int k = 0; k < 4; k++) begin
            cand_valid[k] = elig[ord[k]];
            cand_addr[k*ADDR_W +: ADDR_W] = req_waddr[ord[k]*ADDR_W +: ADDR_W];
        end
    end

    rf_wb_pick2 #(
        .ADDR_W (ADDR_W)
    ) u_pick2 (
        .cand_valid (cand_valid),
        .cand_addr  (cand_addr),
        .sel1       (sel1),
        .sel2       (sel2)
    );

    always_comb begin
        grant1 = '0;
        grant2 = '0;
        for (int k = 0; k < 4; k++) begin
            if (sel1[k]) grant1[ord[k]] = 1'b1;
            if (sel2[k]) grant2[ord[k]] = 1'b1;
        end
    end

    assign grant     = grant1 | grant2;
    assign req_ready = grant & {4{wba_in_rstL}};

    always_comb begin
        addr1 = '0;
        data1 = '0;
        addr2 = '0;
        data2 = '0;
        for (int i = 0; i < 4; i++) begin
            if (grant1[i]) begin
                addr1 = addr1 | req_waddr[i*ADDR_W +: ADDR_W];
                data1 = data1 | req_wdata[i*DATA_W +: DATA_W];
            end
            if (grant2[i]) begin
                addr2 = addr2 | req_waddr[i*ADDR_W +: ADDR_W];
                data2 = data2 | req_wdata[i*DATA_W +: DATA_W];
            end
        end
        bus_d = {(|grant2) && (addr2 != '0), addr2, data2,
                 (|grant1) && (addr1 != '0), addr1, data1};
    end

    assign starv2_d = starv_next(req_valid[REQ_LSU], grant[REQ_LSU], flush, starv2_q);
    assign starv3_d = starv_next(req_valid[REQ_MDU], grant[REQ_MDU], flush, starv3_q);
    assign rr_d     = grant[rr_first] ? ~rr_q : rr_q;
    assign stall_d  = ((|(req_valid & ~grant)) && (stall_q != 16'hFFFF)) ?
                      stall_q + 16'd1 : stall_q;

    always_ff @(posedge wba_in_clk or negedge wba_in_rstL) begin
        if (!wba_in_rstL) begin
            rr_q     <= 1'b0;
            starv2_q <= '0;
            starv3_q <= '0;
            stall_q  <= '0;
            bus_q    <= '0;
        end else begin
            rr_q     <= rr_d;
            starv2_q <= starv2_d;
            starv3_q <= starv3_d;
            stall_q  <= stall_d;
            bus_q    <= bus_d;
        end
    end

    assign write_obus = bus_q;
    assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: directed scenarios then random traffic,
// expectations from a queue-based reference model, checked by a negedge monitor.
module tb_rf_wb_arbiter;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int LIMIT = 4;
    localparam int PW    = 1 + AW + DW;
    localparam int BW    = 2 * PW;

    typedef struct {
        logic [BW-1:0] bus;
        logic [15:0]   stall;
    } out_t;

    logic            clk = 1'b0;
    logic            rst_l;
    logic [3:0]      req_valid;
    logic [4*AW-1:0] req_waddr;
    logic [4*DW-1:0] req_wdata;
    logic [3:0]      req_ready;
    logic            flush;
    logic [BW-1:0]   write_obus;
    logic [15:0]     stall_cnt;

    rf_wb_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .wba_in_clk  (clk),
        .wba_in_rstL (rst_l),
        .req_valid   (req_valid),
        .req_waddr   (req_waddr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .flush       (flush),
        .write_obus  (write_obus),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic mon_en = 1'b0;

    logic [3:0] rdy_q[$];
    out_t       out_q[$];

    logic [3:0]    pend_v;
    logic [AW-1:0] pend_a[4];
    logic [DW-1:0] pend_d[4];

    int m_starv[4];
    int m_rr;
    int m_stall;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (rdy_q.size() != 0) chk("req_ready", 128'(req_ready), 128'(rdy_q.pop_front()));
            if (out_q.size() == 0) begin
                chk("out_queue_underflow", 128'(out_q.size()), 128'(1));
            end else begin
                out_t e;
                e = out_q.pop_front();
                chk("write_obus", 128'(write_obus), 128'(e.bus));
                chk("stall_cnt", 128'(stall_cnt), 128'(e.stall));
            end
        end
    end

    task automatic offer(input int i, input int a);
        if (!pend_v[i]) begin
            pend_v[i] = 1'b1;
            pend_a[i] = AW'(a);
            pend_d[i] = $urandom;
        end
    endtask

    // Drive one cycle, predict its grants and next-cycle outputs, then advance.
    task automatic step(input logic fl);
        int cand[$];
        int other, c, p1, p2;
        logic [3:0] g;
        logic we1, we2;
        logic [AW-1:0] a1, a2;
        logic [DW-1:0] d1, d2;
        out_t e;
        for (int i = 0; i < 4; i++) begin
            req_waddr[i*AW +: AW] = pend_a[i];
            req_wdata[i*DW +: DW] = pend_d[i];
        end
        req_valid = pend_v;
        flush     = fl;

        other = (m_rr == 2) ? 3 : 2;
        cand.push_back(0);
        if (m_starv[m_rr] >= LIMIT) cand.push_back(m_rr);
        if (m_starv[other] >= LIMIT) cand.push_back(other);
        cand.push_back(1);
        if (m_starv[m_rr] < LIMIT) cand.push_back(m_rr);
        if (m_starv[other] < LIMIT) cand.push_back(other);

        p1 = -1;
        p2 = -1;
        for (int k = 0; k < cand.size(); k++) begin
            c = cand[k];
            if (pend_v[c] && !(fl && c != 0)) begin
                if (p1 < 0) p1 = c;
                else if (p2 < 0 && !(pend_a[c] != 0 && pend_a[c] == pend_a[p1])) p2 = c;
            end
        end
        g = '0;
        if (p1 >= 0) g[p1] = 1'b1;
        if (p2 >= 0) g[p2] = 1'b1;

        we1 = 1'b0; a1 = '0; d1 = '0;
        we2 = 1'b0; a2 = '0; d2 = '0;
        if (p1 >= 0) begin a1 = pend_a[p1]; d1 = pend_d[p1]; we1 = (a1 != 0); end
        if (p2 >= 0) begin a2 = pend_a[p2]; d2 = pend_d[p2]; we2 = (a2 != 0); end

        if ((pend_v & ~g) != 0 && m_stall < 65535) m_stall++;
        for (int i = 2; i < 4; i++) begin
            if (!fl) begin
                if (!pend_v[i] || g[i]) m_starv[i] = 0;
                else if (m_starv[i] < 15) m_starv[i]++;
            end
        end
        if (g[m_rr]) m_rr = other;

        e.bus   = {we2, a2, d2, we1, a1, d1};
        e.stall = 16'(m_stall);
        rdy_q.push_back(g);
        out_q.push_back(e);

        @(posedge clk);
        #1;
        pend_v = pend_v & ~g;
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && pend_v != 0; n++) step(1'b0);
        chk("drain_done", 128'(pend_v), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pend_v = '0;
        for (int i = 0; i < 4; i++) begin
            pend_a[i] = '0;
            pend_d[i] = '0;
            m_starv[i] = 0;
        end
        m_rr      = 2;
        m_stall   = 0;
        rst_l     = 1'b0;
        flush     = 1'b0;
        req_valid = 4'hF;
        req_waddr = {5'd4, 5'd3, 5'd2, 5'd1};
        req_wdata = '1;
        #12;
        chk("reset_ready", 128'(req_ready), 128'(0));
        chk("reset_obus", 128'(write_obus), 128'(0));
        chk("reset_stall", 128'(stall_cnt), 128'(0));
        req_valid = '0;
        rst_l     = 1'b1;
        @(posedge clk);
        #1;
        out_q.push_back('{bus: '0, stall: '0});
        mon_en = 1'b1;

        // LSU and MDU alone: both granted, rr pointer moves to MDU.
        offer(2, 5); offer(3, 6);
        step(1'b0);
        // All four valid with distinct addresses.
        offer(0, 1); offer(1, 2); offer(2, 3); offer(3, 4);
        step(1'b0);
        drain();
        // ALU0/ALU1 saturate the ports until LSU starves.
        offer(2, 7);
        for (int k = 0; k < 7; k++) begin
            offer(0, 8 + k);
            offer(1, 16 + k);
            step(1'b0);
        end
        drain();
        // Same-address skip.
        offer(0, 9); offer(1, 9); offer(2, 10);
        step(1'b0);
        drain();
        // Address 0 is granted but not written.
        offer(0, 0); offer(1, 3);
        step(1'b0);
        drain();
        // Flush lets only ALU0 through; the rest stay pending.
        offer(0, 11); offer(1, 12); offer(2, 13); offer(3, 14);
        step(1'b1);
        step(1'b1);
        drain();

        for (int n = 0; n < 500; n++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) != 0) offer(i, int'($urandom_range(0, 7)));
            end
            step($urandom_range(0, 7) == 0);
        end
        drain();
        step(1'b0);

        @(negedge clk);
        #1;
        mon_en = 1'b0;
        chk("out_queue_leftover", 128'(out_q.size()), 128'(0));

        // Asynchronous reset with a live write on the bus.
        req_valid = 4'b0001;
        req_waddr = '0;
        req_waddr[AW-1:0] = 5'd1;
        flush = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_reset_we1", 128'(write_obus[PW-1]), 128'(1));
        #2;
        rst_l = 1'b0;
        #1;
        chk("async_reset_obus", 128'(write_obus), 128'(0));
        chk("async_reset_stall", 128'(stall_cnt), 128'(0));
        chk("async_reset_ready", 128'(req_ready), 128'(0));
        @(posedge clk);
        #1;
        chk("held_reset_obus", 128'(write_obus), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
